// File: rtl/rst_seq.sv
// Reset sequencer: staggers release of NumOut domain resets after the synchronized
// reset, and runs software warm resets with per-domain quiesce handshakes.
module rst_seq #(
    parameter int NumOut        = 4,
    parameter int DelayCycles   = 16,
    parameter int HoldCycles    = 8,
    parameter int TimeoutCycles = 64
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              test_mode_i,
    input  logic              sw_rst_req_i,
    input  logic [NumOut-1:0] quiesce_ack_i,
    output logic [NumOut-1:0] quiesce_req_o,
    output logic [NumOut-1:0] rst_no,
    output logic              done_o,
    output logic              busy_o,
    output logic              timeout_o
);

    localparam int MaxA   = (DelayCycles > HoldCycles) ? DelayCycles : HoldCycles;
    localparam int MaxCyc = (MaxA > TimeoutCycles) ? MaxA : TimeoutCycles;
    localparam int CW     = $clog2(MaxCyc + 1);
    localparam int IW     = (NumOut > 1) ? $clog2(NumOut) : 1;

    localparam logic [CW-1:0] DLY_LAST  = CW'(DelayCycles - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HoldCycles - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TimeoutCycles - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NumOut - 1);

    localparam logic [1:0] S_RELEASE = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_QUIESCE = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    logic [1:0]        state;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     idx_m1;
    logic [CW-1:0]     cnt;
    logic [NumOut-1:0] rst_q;
    logic [NumOut-1:0] qreq_q;
    logic              done_q;
    logic              busy_q;
    logic              to_q;
    logic              ack_cur;

    assign idx_m1  = idx - IW'(1);
    assign ack_cur = quiesce_ack_i[idx];

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_RELEASE;
            idx    <= '0;
            cnt    <= '0;
            rst_q  <= '0;
            qreq_q <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b1;
            to_q   <= 1'b0;
        end else begin
            case (state)
                S_RELEASE: begin
                    if (cnt == DLY_LAST) begin
                        cnt        <= '0;
                        rst_q[idx] <= 1'b1;
                        if (idx == IDX_LAST) begin
                            state  <= S_RUN;
                            idx    <= '0;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RUN: begin
                    if (sw_rst_req_i) begin
                        state            <= S_QUIESCE;
                        idx              <= IDX_LAST;
                        cnt              <= '0;
                        done_q           <= 1'b0;
                        busy_q           <= 1'b1;
                        qreq_q[IDX_LAST] <= 1'b1;
                        to_q             <= 1'b0;
                    end
                end
                S_QUIESCE: begin
                    // A timeout is treated as an ack; a real ack on that edge wins.
                    if (ack_cur || cnt == TO_LAST) begin
                        if (!ack_cur) to_q <= 1'b1;
                        rst_q[idx]  <= 1'b0;
                        qreq_q[idx] <= 1'b0;
                        cnt         <= '0;
                        if (idx != '0) begin
                            qreq_q[idx_m1] <= 1'b1;
                            idx            <= idx_m1;
                        end else begin
                            state <= S_HOLD;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_HOLD: begin
                    rst_q <= '0;
                    if (cnt == HOLD_LAST) begin
                        state <= S_RELEASE;
                        cnt   <= '0;
                        idx   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= S_RELEASE;
            endcase
        end
    end

    // Test mode hands every domain reset straight to the input reset for scan.
    assign rst_no        = test_mode_i ? {NumOut{rst_n}} : rst_q;
    assign quiesce_req_o = test_mode_i ? '0 : qreq_q;
    assign done_o        = test_mode_i ? 1'b1 : done_q;
    assign busy_o        = test_mode_i ? 1'b0 : busy_q;
    assign timeout_o     = to_q;

endmodule

// File: doc/rst_seq.md
Name: rst_seq

Overview:
- Reset sequencer sitting directly downstream of the reset synchronizer. It consumes the synchronized active-low reset and releases NumOut domain resets one after another, with a fixed spacing between them.
- It also executes software-requested warm resets. For each domain, in reverse order, it runs a quiesce request/acknowledge handshake (with timeout), asserts that domain's reset, holds all domains in reset, then re-runs the release sequence.
- A test-mode bypass makes every output reset follow the input reset directly, so scan/DFT has direct control.

Parameters:
- NumOut, 4: number of sequenced reset domains (>=1).
- DelayCycles, 16: clock cycles between successive domain releases (>=1).
- HoldCycles, 8: cycles all domains stay in reset during a warm reset (>=1).
- TimeoutCycles, 64: maximum cycles to wait for a quiesce ack per domain (>=1).

Ports:
- clk_i  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low; this is the synchronized reset output of the synchronizer stage.
- test_mode_i  in  1  DFT bypass enable.
- sw_rst_req_i  in  1  warm-reset request, sampled on posedge.
- quiesce_ack_i  in  NumOut  per-domain "idle, safe to reset" acknowledge.
- quiesce_req_o  out  NumOut  per-domain quiesce request.
- rst_no  out  NumOut  per-domain reset, active-low; bit 0 is released first.
- done_o  out  1  all domains released, FSM in RUN.
- busy_o  out  1  FSM not in RUN.
- timeout_o  out  1  sticky flag: a quiesce handshake timed out.

Behaviour:
- Reset values (rst_n=0, asynchronous): rst_no='0, quiesce_req_o='0, done_o=0, busy_o=1, timeout_o=0. The FSM goes to RELEASE with idx=0 and cnt=0.
- State machine states: RELEASE, RUN, QUIESCE, HOLD. All outputs are registered.
- RELEASE:
  - cnt increments every edge.
  - When cnt reaches DelayCycles-1: rst_no[idx] goes to 1 on that edge, cnt is cleared, and idx increments.
  - Consequence: rst_no[i] rises exactly (i+1)*DelayCycles edges after entry. For power-up, edge 1 is the first posedge with rst_n=1.
  - On release of idx=NumOut-1: the FSM moves to RUN, and done_o=1, busy_o=0 take effect on the same edge.
- RUN:
  - If sw_rst_req_i=1 at an edge: go to QUIESCE with idx=NumOut-1, cnt=0. On that edge done_o=0, busy_o=1, quiesce_req_o[NumOut-1]=1, and timeout_o is cleared.
  - sw_rst_req_i is ignored in every state other than RUN. Requests are not queued.
- QUIESCE, each edge:
  - If quiesce_ack_i[idx]=1: rst_no[idx]=0 and quiesce_req_o[idx]=0. If idx>0, quiesce_req_o[idx-1]=1 on the same edge, idx decrements and cnt is cleared; if idx=0, go to HOLD with cnt=0.
  - Else cnt increments. When cnt reaches TimeoutCycles-1, the domain is treated as acknowledged (same actions as above) and timeout_o is set to 1.
  - An ack arriving on the timeout edge counts as an ack; timeout_o is not set.
  - An ack that is already high when the request rises takes effect on the next edge, so the request is high for a minimum of 1 cycle.
  - Exactly one quiesce_req_o bit is high at any time while in QUIESCE.
- HOLD: all rst_no=0. After HoldCycles edges, go to RELEASE with idx=0, cnt=0. Release timing is then identical to power-up, counted from the entry edge.
- Counter width is $clog2 of max(DelayCycles, HoldCycles, TimeoutCycles)+1. There is no wrap: the counter is always cleared on a state or idx change.
- Reset mid-operation: rst_n=0 in any state immediately forces the reset values above, including aborting an in-flight quiesce.
- Test mode (test_mode_i=1), combinational override of the outputs:
  - rst_no = {NumOut{rst_n}}, quiesce_req_o='0, done_o=1, busy_o=0.
  - The internal FSM keeps running and is not observable.
  - Deasserting test_mode_i returns the outputs to their registered values.

Test Plan:
- Power-up, defaults: release rst_n at edge 0 -> rst_no[0..3] rise at edges 16/32/48/64; done_o=1 and busy_o=0 at edge 64; quiesce_req_o stays 0.
- Warm reset, ack tied high: sw_rst_req_i pulse at edge E in RUN:
  - quiesce_req_o[3] rises at E; rst_no[3] falls at E+1; rst_no[2..0] fall at E+2, E+3, E+4.
  - HOLD ends at E+12; rst_no[0] rises at E+28 and rst_no[3] at E+76; timeout_o stays 0.
- Timeout: ack[2] held 0, all others 1 -> quiesce_req_o[2] stays high for exactly 64 cycles; rst_no[2] falls at the 64th edge; timeout_o=1 and remains set until the next sw_rst_req_i.
- Reset mid-QUIESCE: assert rst_n=0 while quiesce_req_o[1]=1 -> all outputs immediately take reset values; on rst_n release, the power-up sequence repeats exactly.
- Ignored request: pulse sw_rst_req_i during RELEASE (e.g. edge 20) -> no effect; the sequence finishes at edge 64 and the FSM stays in RUN.
- Test mode: test_mode_i=1, toggle rst_n -> rst_no follows rst_n on all 4 bits with zero latency; done_o=1, quiesce_req_o='0.
